// File: rtl/fatori_mon_err_aggregator.sv
// Error aggregator for hardened M-of-N wrappers: edge-counted min/maj/scrub events, stickies, health FSM, clear handshake. Optional FATORI_MON_AGG_TIMESTAMP_EN stamps the first majority error.
// Latency: an input rising in cycle t is reflected in counters, stickies and state in cycle t+2; readback is combinational.
// Backpressure: none on error inputs; clr_req_i is held until clr_ack_o pulses, then must drop before the next request is accepted.
module fatori_mon_err_aggregator #(
  parameter int NSRC      = 4,
  parameter int CNT_W     = 16,
  parameter int MIN_LIMIT = 8,
  localparam int SEL_W    = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NSRC-1:0]  min_err_i,
  input  logic [NSRC-1:0]  maj_err_i,
  input  logic [NSRC-1:0]  scrub_i,
  input  logic             clr_req_i,
  output logic             clr_ack_o,
  input  logic [SEL_W-1:0] rd_sel_i,
  output logic [CNT_W-1:0] rd_min_cnt_o,
  output logic [CNT_W-1:0] rd_maj_cnt_o,
  output logic [CNT_W-1:0] rd_scrub_cnt_o,
  output logic [NSRC-1:0]  min_sticky_o,
  output logic [NSRC-1:0]  maj_sticky_o,
  output logic [1:0]       state_o,
  output logic             alert_o,
  output logic             fatal_o,
  output logic             first_valid_o,
  output logic [SEL_W-1:0] first_src_o,
  output logic [31:0]      first_ts_o
);

  typedef enum logic [1:0] {ST_OK = 2'd0, ST_DEG = 2'd1, ST_FATAL = 2'd2} st_t;
  typedef enum logic [1:0] {HS_IDLE = 2'd0, HS_ACK = 2'd1, HS_WAIT = 2'd2} hs_t;

  st_t st_q, st_d;
  hs_t hs_q, hs_d;

  logic [NSRC-1:0] min_q, min_qq, maj_q, maj_qq, scr_q, scr_qq;
  logic [NSRC-1:0] min_ev, maj_ev, scr_ev;
  logic [CNT_W-1:0] min_cnt [NSRC];
  logic [CNT_W-1:0] maj_cnt [NSRC];
  logic [CNT_W-1:0] scr_cnt [NSRC];
  logic [NSRC-1:0] min_sticky_q, maj_sticky_q;
  logic [31:0] tot_q, tot_base, tot_d, min_pop;
  logic [32:0] tot_sum;
  logic do_clr, limit_hit, capture, fv_base;
  logic first_valid_q;
  logic [SEL_W-1:0] first_src_q, first_src_d;

  assign min_ev = min_q & ~min_qq;
  assign maj_ev = maj_q & ~maj_qq;
  assign scr_ev = scr_q & ~scr_qq;
  assign do_clr = (hs_q == HS_IDLE) && clr_req_i;

  // Clear is applied before the coincident event, so a counter can restart at 1.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic ev, input logic clr);
    logic [CNT_W-1:0] b;
    b = clr ? '0 : c;
    if (ev && (b != {CNT_W{1'b1}})) b = b + CNT_W'(1);
    return b;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      min_q <= '0; min_qq <= '0;
      maj_q <= '0; maj_qq <= '0;
      scr_q <= '0; scr_qq <= '0;
      for (int i = 0; i < NSRC; i++) begin
        min_cnt[i] <= '0;
        maj_cnt[i] <= '0;
        scr_cnt[i] <= '0;
      end
      min_sticky_q  <= '0;
      maj_sticky_q  <= '0;
      tot_q         <= '0;
      st_q          <= ST_OK;
      hs_q          <= HS_IDLE;
      first_valid_q <= 1'b0;
      first_src_q   <= '0;
    end else begin
      min_q <= min_err_i; min_qq <= min_q;
      maj_q <= maj_err_i; maj_qq <= maj_q;
      scr_q <= scrub_i;   scr_qq <= scr_q;
      for (int i = 0; i < NSRC; i++) begin
        min_cnt[i] <= cnt_next(min_cnt[i], min_ev[i], do_clr);
        maj_cnt[i] <= cnt_next(maj_cnt[i], maj_ev[i], do_clr);
        scr_cnt[i] <= cnt_next(scr_cnt[i], scr_ev[i], do_clr);
      end
      min_sticky_q  <= (do_clr ? '0 : min_sticky_q) | min_ev;
      maj_sticky_q  <= (do_clr ? '0 : maj_sticky_q) | maj_ev;
      tot_q         <= tot_d;
      st_q          <= st_d;
      hs_q          <= hs_d;
      first_valid_q <= fv_base | capture;
      first_src_q   <= first_src_d;
    end
  end

  always_comb begin
    min_pop = '0;
    for (int i = 0; i < NSRC; i++) min_pop = min_pop + 32'(min_ev[i]);
    tot_base  = do_clr ? '0 : tot_q;
    tot_sum   = {1'b0, tot_base} + {1'b0, min_pop};
    tot_d     = tot_sum[32] ? 32'hFFFF_FFFF : tot_sum[31:0];
    limit_hit = (MIN_LIMIT != 0) && (tot_d >= 32'(MIN_LIMIT));
  end

  always_comb begin
    st_d = st_q;
    if (do_clr && (st_q == ST_DEG)) st_d = ST_OK;
    if (st_d != ST_FATAL) begin
      if ((|maj_ev) || limit_hit) st_d = ST_FATAL;
      else if ((st_d == ST_OK) && ((|min_ev) || (|scr_ev))) st_d = ST_DEG;
    end
  end

  always_comb begin
    hs_d = hs_q;
    case (hs_q)
      HS_IDLE: if (clr_req_i) hs_d = HS_ACK;
      HS_ACK:  hs_d = HS_WAIT;
      HS_WAIT: if (!clr_req_i) hs_d = HS_IDLE;
      default: hs_d = HS_IDLE;
    endcase
  end

  // Descending scan so the lowest firing source index is the one kept.
  always_comb begin
    fv_base     = do_clr ? 1'b0 : first_valid_q;
    capture     = !fv_base && (|maj_ev);
    first_src_d = do_clr ? '0 : first_src_q;
    if (capture) begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (maj_ev[i]) first_src_d = SEL_W'(i);
      end
    end
  end

`ifdef FATORI_MON_AGG_TIMESTAMP_EN
  logic [31:0] ts_q, first_ts_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ts_q       <= '0;
      first_ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (capture)     first_ts_q <= ts_q;
      else if (do_clr) first_ts_q <= '0;
    end
  end
  assign first_ts_o = first_ts_q;
`else
  assign first_ts_o = '0;
`endif

  always_comb begin
    rd_min_cnt_o   = '0;
    rd_maj_cnt_o   = '0;
    rd_scrub_cnt_o = '0;
    if (int'(rd_sel_i) < NSRC) begin
      rd_min_cnt_o   = min_cnt[rd_sel_i];
      rd_maj_cnt_o   = maj_cnt[rd_sel_i];
      rd_scrub_cnt_o = scr_cnt[rd_sel_i];
    end
  end

  assign clr_ack_o     = (hs_q == HS_ACK);
  assign min_sticky_o  = min_sticky_q;
  assign maj_sticky_o  = maj_sticky_q;
  assign state_o       = st_q;
  assign alert_o       = (st_q == ST_DEG) || (st_q == ST_FATAL);
  assign fatal_o       = (st_q == ST_FATAL);
  assign first_valid_o = first_valid_q;
  assign first_src_o   = first_src_q;

endmodule

// File: tb/tb_fatori_mon_err_aggregator.sv
// Directed bench for fatori_mon_err_aggregator (NSRC=4, CNT_W=4, MIN_LIMIT=8).
module tb_fatori_mon_err_aggregator;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  min_err_i, maj_err_i, scrub_i;
  logic        clr_req_i;
  logic        clr_ack_o;
  logic [1:0]  rd_sel_i;
  logic [3:0]  rd_min_cnt_o, rd_maj_cnt_o, rd_scrub_cnt_o;
  logic [3:0]  min_sticky_o, maj_sticky_o;
  logic [1:0]  state_o;
  logic        alert_o, fatal_o, first_valid_o;
  logic [1:0]  first_src_o;
  logic [31:0] first_ts_o;

  int checks   = 0;
  int failures = 0;
  int acks;

  fatori_mon_err_aggregator #(.NSRC(4), .CNT_W(4), .MIN_LIMIT(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .min_err_i(min_err_i), .maj_err_i(maj_err_i), .scrub_i(scrub_i),
    .clr_req_i(clr_req_i), .clr_ack_o(clr_ack_o), .rd_sel_i(rd_sel_i),
    .rd_min_cnt_o(rd_min_cnt_o), .rd_maj_cnt_o(rd_maj_cnt_o), .rd_scrub_cnt_o(rd_scrub_cnt_o),
    .min_sticky_o(min_sticky_o), .maj_sticky_o(maj_sticky_o),
    .state_o(state_o), .alert_o(alert_o), .fatal_o(fatal_o),
    .first_valid_o(first_valid_o), .first_src_o(first_src_o), .first_ts_o(first_ts_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1; min_err_i = '0; maj_err_i = '0; scrub_i = '0;
    clr_req_i = 1'b0; rd_sel_i = 2'd2;
    tick(); tick();
    chk("rst_state", state_o, 0);
    chk("rst_alert", alert_o, 0);
    chk("rst_fatal", fatal_o, 0);
    chk("rst_ack", clr_ack_o, 0);
    chk("rst_min_sticky", min_sticky_o, 0);
    chk("rst_maj_sticky", maj_sticky_o, 0);
    chk("rst_first_valid", first_valid_o, 0);
    chk("rst_first_src", first_src_o, 0);
    chk("rst_first_ts", first_ts_o, 0);
    chk("rst_rd_min", rd_min_cnt_o, 0);
    rst_i = 1'b0;
    tick();

    // Minority level on source 2 held for 5 cycles
    min_err_i[2] = 1'b1;
    tick();
    chk("min_t1_state", state_o, 0);
    chk("min_t1_cnt", rd_min_cnt_o, 0);
    tick();
    chk("min_t2_cnt", rd_min_cnt_o, 1);
    chk("min_t2_sticky", min_sticky_o, 4'b0100);
    chk("min_t2_state", state_o, 1);
    chk("min_t2_alert", alert_o, 1);
    chk("min_t2_fatal", fatal_o, 0);
    tick(); tick(); tick();
    min_err_i[2] = 1'b0;
    tick(); tick();
    chk("min_held_cnt", rd_min_cnt_o, 1);

    // Scrub saturation on source 0
    rd_sel_i = 2'd0;
    for (int i = 0; i < 20; i++) begin
      scrub_i[0] = 1'b1; tick();
      scrub_i[0] = 1'b0; tick();
    end
    tick();
    chk("scrub_sat", rd_scrub_cnt_o, 15);
    chk("scrub_state", state_o, 1);

    // Clear handshake from DEGRADED with request held 6 cycles
    clr_req_i = 1'b1;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      acks += int'(clr_ack_o);
    end
    chk("clr_ack_count", acks, 1);
    chk("clr_state", state_o, 0);
    chk("clr_sticky", min_sticky_o, 0);
    chk("clr_scrub_cnt", rd_scrub_cnt_o, 0);
    rd_sel_i = 2'd2; #1;
    chk("clr_min_cnt", rd_min_cnt_o, 0);
    clr_req_i = 1'b0;
    tick(); tick();
    chk("clr_no_ack_idle", clr_ack_o, 0);
    clr_req_i = 1'b1;
    tick();
    chk("clr_second_ack", clr_ack_o, 1);
    clr_req_i = 1'b0;
    tick(); tick();

    // Total minority limit: FATAL on the 8th event, not the 7th
    rd_sel_i = 2'd0;
    for (int i = 0; i < 7; i++) begin
      min_err_i[i % 4] = 1'b1; tick();
      min_err_i = '0; tick();
    end
    chk("lim_after7", state_o, 1);
    min_err_i[3] = 1'b1; tick();
    min_err_i = '0; tick();
    chk("lim_after8", state_o, 2);
    chk("lim_fatal", fatal_o, 1);
    chk("lim_alert", alert_o, 1);
    chk("lim_src0_cnt", rd_min_cnt_o, 2);
    chk("lim_sticky", min_sticky_o, 4'b1111);

    // Clear in FATAL clears counters only, then async reset mid-handshake
    clr_req_i = 1'b1;
    tick();
    chk("fat_clr_ack", clr_ack_o, 1);
    chk("fat_clr_state", state_o, 2);
    chk("fat_clr_cnt", rd_min_cnt_o, 0);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_ack", clr_ack_o, 0);
    chk("arst_state", state_o, 0);
    chk("arst_fatal", fatal_o, 0);
    chk("arst_alert", alert_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0; clr_req_i = 1'b0;
    tick();

    // Coincident majority on sources 1 and 3: lowest index wins
    rd_sel_i = 2'd1;
    maj_err_i = 4'b1010;
    tick(); tick();
    chk("maj_first_valid", first_valid_o, 1);
    chk("maj_first_src", first_src_o, 1);
    chk("maj_state", state_o, 2);
    chk("maj_sticky", maj_sticky_o, 4'b1010);
    chk("maj_cnt1", rd_maj_cnt_o, 1);
    maj_err_i = '0; tick();
    maj_err_i = 4'b0001; tick(); tick();
    chk("maj_later_src", first_src_o, 1);
    chk("maj_later_sticky", maj_sticky_o, 4'b1011);
    maj_err_i = '0;
    clr_req_i = 1'b1;
    tick();
    chk("maj_clr_valid", first_valid_o, 0);
    chk("maj_clr_src", first_src_o, 0);
    chk("maj_clr_sticky", maj_sticky_o, 0);
    chk("maj_clr_cnt", rd_maj_cnt_o, 0);
    chk("maj_clr_state", state_o, 2);
    clr_req_i = 1'b0;
    tick(); tick();

    // Timestamp of a majority event raised in cycle 37 after reset
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (36) tick();
    maj_err_i[3] = 1'b1;
    tick(); tick();
    chk("ts_first_src", first_src_o, 3);
    chk("ts_first_valid", first_valid_o, 1);
`ifdef FATORI_MON_AGG_TIMESTAMP_EN
    chk("ts_value", first_ts_o, 37);
`else
    chk("ts_value", first_ts_o, 0);
`endif
    maj_err_i = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fatori_mon_err_aggregator.md
Name: fatori_mon_err_aggregator

Overview:
Downstream collector for the min/maj/scrub status pins of every hardened M-of-N wrapper in the core (ALU, decoder, LSU, register file, ...). It converts level error indications into counted events and keeps per-source sticky flags. A health FSM drives alert/fatal outputs to the SoC. Software reads counters through a select port and clears them with a req/ack handshake.

Parameters:
NSRC, 4, number of hardened wrappers feeding the block (1..16)
CNT_W, 16, width of each saturating event counter
MIN_LIMIT, 8, total minority events (summed over all sources) that escalate DEGRADED to FATAL; 0 disables escalation

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
min_err_i  in  NSRC  per-source minority disagreement (level, from voter)
maj_err_i  in  NSRC  per-source no-majority error (level)
scrub_i  in  NSRC  per-source scrub-occurred indication (level)
clr_req_i  in  1  clear request, held until clr_ack_o seen
clr_ack_o  out  1  clear acknowledge, one-cycle pulse
rd_sel_i  in  $clog2(NSRC) (min 1)  source select for counter readback
rd_min_cnt_o  out  CNT_W  minority event count of selected source
rd_maj_cnt_o  out  CNT_W  majority event count of selected source
rd_scrub_cnt_o  out  CNT_W  scrub event count of selected source
min_sticky_o  out  NSRC  per-source sticky minority flag
maj_sticky_o  out  NSRC  per-source sticky majority flag
state_o  out  2  health state: 0 OK, 1 DEGRADED, 2 FATAL
alert_o  out  1  high while state is DEGRADED or FATAL
fatal_o  out  1  high while state is FATAL
first_valid_o  out  1  first majority source captured
first_src_o  out  $clog2(NSRC) (min 1)  index of first majority source
first_ts_o  out  32  cycle stamp of first majority event (see Optional Feature)

Behaviour:
- Reset (async, any time, including mid-clear): all counters, stickies, input registers, first_* fields and clr_ack_o go to 0. State goes to OK. All outputs are 0.
- Input stage: min/maj/scrub are registered once (in_q), then once more (in_qq). An event is in_q & ~in_qq, one event per rising edge. A level held N cycles counts 1.
- Latency: input rises in cycle t. Counters, stickies and state are visible in cycle t+2.
- Counters: one per source per type. Each increments by 1 per event and saturates at 2^CNT_W-1 (no wrap). Events from different sources in the same cycle update each counter independently.
- Total-min accumulator: internal, also saturating. It adds the popcount of min events in that cycle.
- Stickies: set on event. Cleared only by the clear handshake or reset.
- Readback: rd_*_cnt_o are combinational muxes of the counter arrays by rd_sel_i. Out-of-range rd_sel_i returns 0.
- FSM:
  - OK -> DEGRADED on any min or scrub event.
  - OK/DEGRADED -> FATAL on any maj event, or when the total-min accumulator reaches MIN_LIMIT (MIN_LIMIT != 0).
  - DEGRADED -> OK only via clear.
  - FATAL is absorbing; only reset leaves it.
- First-error capture: on the first maj event while first_valid_o=0, latch the source index and set first_valid_o. When several sources fire in that cycle, the lowest index wins.
- Clear handshake:
  - clr_req_i high while idle (HS_IDLE): in the next edge, clear counters, stickies, total accumulator and first_* fields, move DEGRADED->OK, and pulse clr_ack_o for one cycle (HS_ACK).
  - The block then waits in HS_WAIT until clr_req_i is low before accepting another request. A held request yields exactly one ack.
  - FATAL state is unaffected by clear; counters are still cleared.
- Event coincident with the clear edge: the clear applies first, then the event. The counter reads 1, the sticky is set, and the FSM re-evaluates from OK (may go DEGRADED/FATAL).

Optional Feature:
FATORI_MON_AGG_TIMESTAMP_EN
- Defined: a 32-bit free-running cycle counter (reset 0, wraps at 2^32) runs in the block. Its value is latched into first_ts_o together with first_src_o. The latch clears on clear handshake.
- Undefined: no timestamp counter exists and first_ts_o is tied to 0.

Test Plan:
- Reset, then pulse min_err_i[2] high for 5 cycles -> rd_sel_i=2 gives rd_min_cnt_o=1, min_sticky_o=4'b0100, state_o=1, alert_o=1, fatal_o=0, visible exactly 2 cycles after the rise.
- CNT_W=4; toggle scrub_i[0] 20 times -> rd_scrub_cnt_o=15 (saturated), no wrap.
- maj_err_i=4'b1010 rising in the same cycle -> first_src_o=1, first_valid_o=1, state_o=2. A later maj on source 0 leaves first_src_o=1.
- MIN_LIMIT=8; eight separate min events spread over sources 0..3 -> state_o=2 after the 8th, not after the 7th.
- DEGRADED, hold clr_req_i 6 cycles -> single clr_ack_o pulse, counters=0, stickies=0, state_o=0. A second ack comes only after clr_req_i drops and is re-raised.
- Assert rst_i mid-handshake while in FATAL -> all outputs 0 immediately (async), state_o=0. With FATORI_MON_AGG_TIMESTAMP_EN, a maj event at cycle 37 after reset gives first_ts_o=37±input latency, and first_ts_o is 0 without the macro.
